// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states, ACK/NACK levels, address width.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer plus registered rise/fall detect; level and edge pulses are aligned,
// STAGES+1 clk after the input changes. No backpressure.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              lvl_q;
    logic              rise_q;
    logic              fall_q;

    // Idle bus is high, so everything resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            lvl_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            lvl_q  <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~lvl_q;
            fall_q <= ~sync_q[STAGES-1] & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target (7-bit address, read/write, no clock stretching) with byte-level user handshake.
// Bus events act SYNC_STAGES+1 clk after the pin edge; tx_data must be ready when tx_req pulses.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDRESS     = 7'h27,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       error
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .d_i(scl_in),
        .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .d_i(sda_in),
        .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rw_q, rw_d;
    logic       addressed_q, addressed_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       error_q, error_d;
    logic       frac_q, frac_d;
    logic       ack_q, ack_d;
    logic       tx_load;

    logic       start_cond, stop_cond, mid_byte;
    logic [7:0] shifted;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign shifted    = {shift_q[6:0], sda_lvl};
    // frac_q marks a bit whose full SCL pulse has passed; the rise that precedes a
    // normal STOP/repeated START leaves it clear, so only a truncated byte flags error.
    assign mid_byte   = ((state_q == WR_BYTE) || (state_q == RD_BYTE)) && frac_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        rx_valid_d  = 1'b0;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        error_d     = error_q;
        frac_d      = frac_q;
        ack_d       = ack_q;
        tx_load     = 1'b0;

        if (start_cond) begin
            state_d     = ADDR;
            cnt_d       = 4'd0;
            shift_d     = 8'h00;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            start_d     = 1'b1;
            error_d     = mid_byte;
            frac_d      = 1'b0;
        end else if (stop_cond) begin
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            stop_d      = 1'b1;
            error_d     = error_q | mid_byte;
            frac_d      = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (shifted[7:1] == ADDRESS) begin
                                state_d     = ADDR_ACK;
                                addressed_d = 1'b1;
                                rw_d        = shifted[0];
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            frac_d   = 1'b0;
                            if (rw_q) begin
                                tx_load  = 1'b1;
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[7];
                                state_d  = RD_BYTE;
                            end else begin
                                state_d = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            cnt_d      = 4'd0;
                            frac_d     = 1'b0;
                            state_d    = WR_ACK;
                        end
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        frac_d = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ack_d    = 1'b0;
                            frac_d   = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            frac_d   = 1'b1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            ack_d = 1'b1;
                        end else begin
                            state_d     = WAIT_STOP;
                            addressed_d = 1'b0;
                        end
                    end else if (scl_fall && ack_q) begin
                        tx_load  = 1'b1;
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        cnt_d    = 4'd0;
                        state_d  = RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            error_q     <= 1'b0;
            frac_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            error_q     <= error_d;
            frac_q      <= frac_d;
            ack_q       <= ack_d;
        end
    end

    // Gating with rst lets a reset drop the SDA pull-down in the same cycle.
    assign sda_oe    = sda_oe_q & ~rst;
    assign tx_req    = tx_load & ~rst;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rw        = rw_q;
    assign addressed = addressed_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign error     = error_q;

endmodule
